// File: rtl/irq_pending_ctrl.sv
// Interrupt pending/presentation controller: sticky capture, mask qualify,
// highest-index select, valid/ack handshake. Define IRQ_EDGE_EN for edge capture.
module irq_pending_ctrl #(
  parameter int N = 8,
  parameter int M = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] irq_in,
  input  logic [N-1:0] mask,
  input  logic         irq_ack,
  output logic         irq_valid,
  output logic [M-1:0] irq_id,
  output logic [N-1:0] pending
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  state_t       state;
  logic [N-1:0] set_vec;
  logic [N-1:0] clr_vec;
  logic [N-1:0] qual;
  logic [M-1:0] sel_id;
  logic         sel_any;

`ifdef IRQ_EDGE_EN
  logic [N-1:0] irq_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_d <= '0;
    end else begin
      irq_d <= irq_in;
    end
  end

  assign set_vec = irq_in & ~irq_d;
`else
  assign set_vec = irq_in;
`endif

  // Only the presented line is cleared, and only on an ack while presenting.
  always_comb begin
    clr_vec = '0;
    if (state == PRESENT && irq_ack) begin
      for (int i = 0; i < N; i++) begin
        if (irq_id == M'(i)) begin
          clr_vec[i] = 1'b1;
        end
      end
    end
  end

  assign qual = pending & mask;

  // Ascending scan so the highest set index is the last one written.
  always_comb begin
    sel_id  = '0;
    sel_any = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (qual[i]) begin
        sel_id  = M'(i);
        sel_any = 1'b1;
      end
    end
  end

  // Set is applied after clear so a same-cycle request survives the ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr_vec) | set_vec;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      irq_valid <= 1'b0;
      irq_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_any) begin
            irq_id    <= sel_id;
            irq_valid <= 1'b1;
            state     <= PRESENT;
          end else begin
            irq_valid <= 1'b0;
          end
        end
        PRESENT: begin
          if (irq_ack) begin
            irq_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          irq_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed bench for irq_pending_ctrl; expected values are hand-computed,
// with the hold-high mode scenario adjusted by IRQ_EDGE_EN.
module tb_irq_pending_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] irq_in;
  logic [7:0] mask;
  logic       irq_ack;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic [7:0] pending;

  int total;
  int bad;
  int acks;

  irq_pending_ctrl #(.N(8), .M(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .irq_in   (irq_in),
    .mask     (mask),
    .irq_ack  (irq_ack),
    .irq_valid(irq_valid),
    .irq_id   (irq_id),
    .pending  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs at a falling edge, then advance past one rising edge.
  task automatic applyStimulus(input logic [7:0] irq, input logic ack);
    irq_in  = irq;
    irq_ack = ack;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("[TB] %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkState(input string tag, input logic v, input logic [2:0] id, input logic [7:0] p);
    checkOutput({tag, ".valid"}, 32'(irq_valid), 32'(v));
    if (v) checkOutput({tag, ".id"}, 32'(irq_id), 32'(id));
    checkOutput({tag, ".pending"}, 32'(pending), 32'(p));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    irq_in  = '0;
    mask    = 8'hFF;
    irq_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("reset.valid", 32'(irq_valid), 32'd0);
    checkOutput("reset.id", 32'(irq_id), 32'd0);
    checkOutput("reset.pending", 32'(pending), 32'd0);
    rst = 1'b0;

    $display("[TB] reset mid-handshake");
    applyStimulus(8'h81, 1'b0);
    checkState("rst_cap", 1'b0, 3'd0, 8'h81);
    applyStimulus(8'h00, 1'b0);
    checkState("rst_pres", 1'b1, 3'd7, 8'h81);
    rst = 1'b1;
    #1;
    checkOutput("rst_async.valid", 32'(irq_valid), 32'd0);
    checkOutput("rst_async.id", 32'(irq_id), 32'd0);
    checkOutput("rst_async.pending", 32'(pending), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(8'h00, 1'b0);
      checkOutput("rst_quiet.valid", 32'(irq_valid), 32'd0);
    end

    $display("[TB] priority");
    mask = 8'hFF;
    applyStimulus(8'h24, 1'b0);
    checkState("pri_cap", 1'b0, 3'd0, 8'h24);
    applyStimulus(8'h00, 1'b0);
    checkState("pri_first", 1'b1, 3'd5, 8'h24);
    applyStimulus(8'h00, 1'b1);
    checkState("pri_ack1", 1'b0, 3'd0, 8'h04);
    applyStimulus(8'h00, 1'b0);
    checkState("pri_second", 1'b1, 3'd2, 8'h04);
    applyStimulus(8'h00, 1'b1);
    checkState("pri_ack2", 1'b0, 3'd0, 8'h00);

    $display("[TB] masking");
    mask = 8'h0F;
    applyStimulus(8'h90, 1'b0);
    checkState("msk_cap", 1'b0, 3'd0, 8'h90);
    applyStimulus(8'h00, 1'b0);
    checkState("msk_hold1", 1'b0, 3'd0, 8'h90);
    applyStimulus(8'h00, 1'b0);
    checkState("msk_hold2", 1'b0, 3'd0, 8'h90);
    mask = 8'hFF;
    applyStimulus(8'h00, 1'b0);
    checkState("msk_open", 1'b1, 3'd7, 8'h90);
    applyStimulus(8'h00, 1'b1);
    checkState("msk_ack1", 1'b0, 3'd0, 8'h10);
    applyStimulus(8'h00, 1'b0);
    checkState("msk_next", 1'b1, 3'd4, 8'h10);
    applyStimulus(8'h00, 1'b1);
    checkState("msk_ack2", 1'b0, 3'd0, 8'h00);

    $display("[TB] hold and no-preempt");
    applyStimulus(8'h02, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkState("hold_pres", 1'b1, 3'd1, 8'h02);
    applyStimulus(8'h40, 1'b0);
    checkState("hold_arrive", 1'b1, 3'd1, 8'h42);
    mask = 8'h00;
    applyStimulus(8'h00, 1'b0);
    checkState("hold_masked", 1'b1, 3'd1, 8'h42);
    mask = 8'hFF;
    applyStimulus(8'h00, 1'b1);
    checkState("hold_ack", 1'b0, 3'd0, 8'h40);
    applyStimulus(8'h00, 1'b0);
    checkState("hold_next", 1'b1, 3'd6, 8'h40);
    applyStimulus(8'h00, 1'b1);
    checkState("hold_done", 1'b0, 3'd0, 8'h00);

    $display("[TB] set wins over ack");
    applyStimulus(8'h08, 1'b0);
    applyStimulus(8'h00, 1'b0);
    checkState("sw_pres", 1'b1, 3'd3, 8'h08);
    applyStimulus(8'h08, 1'b1);
    checkState("sw_ack", 1'b0, 3'd0, 8'h08);
    applyStimulus(8'h00, 1'b0);
    checkState("sw_again", 1'b1, 3'd3, 8'h08);
    applyStimulus(8'h00, 1'b1);
    checkState("sw_done", 1'b0, 3'd0, 8'h00);

    $display("[TB] ack ignored while idle");
    mask = 8'h00;
    applyStimulus(8'h01, 1'b0);
    applyStimulus(8'h00, 1'b1);
    checkState("idle_ack", 1'b0, 3'd0, 8'h01);
    mask = 8'hFF;
    applyStimulus(8'h00, 1'b0);
    checkState("idle_pres", 1'b1, 3'd0, 8'h01);
    applyStimulus(8'h00, 1'b1);
    checkState("idle_done", 1'b0, 3'd0, 8'h00);
    applyStimulus(8'h00, 1'b0);

    $display("[TB] capture mode with line held high");
    acks = 0;
    for (int i = 0; i < 6; i++) begin
      if (irq_valid) acks++;
      applyStimulus(8'h01, irq_valid);
    end
    for (int i = 0; i < 6; i++) begin
      if (irq_valid) acks++;
      applyStimulus(8'h00, irq_valid);
    end
`ifdef IRQ_EDGE_EN
    checkOutput("mode.presentations", 32'(acks), 32'd1);
`else
    checkOutput("mode.presentations", 32'(acks), 32'd3);
`endif
    checkState("mode_end", 1'b0, 3'd0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/irq_pending_ctrl.md
# irq_pending_ctrl

Interrupt pending/presentation controller for the general-logic library. It captures N request lines into a sticky pending register, qualifies them with an enable mask, and selects the highest-index qualified bit with the same highest-index-wins priority rule as `priority_encoder`. It then holds that index on a valid/ack handshake until a consumer acknowledges it. The block sits between raw request sources and an interrupt-servicing consumer.

## Interface
- `N`, 8: number of request lines; `N` ≥ 2.
- `M`, `$clog2(N)`: width of the index output.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `irq_in`  in  N  raw request lines.
- `mask`  in  N  per-line enable; 1 = line may be presented.
- `irq_ack`  in  1  consumer acknowledge; only meaningful while `irq_valid` = 1.
- `irq_valid`  out  1  a presented request is pending acknowledgement.
- `irq_id`  out  M  index of the presented request.
- `pending`  out  N  sticky pending register; masked and unmasked bits are both visible.

## Operation
- Reset values: `pending` = 0, `irq_valid` = 0, `irq_id` = 0, FSM = IDLE, edge-history register = 0.
- Capture: `pending[i]` is set on a clock edge when the capture condition for line i holds. Level or edge capture is selected by the macro in Configuration.
- Capture ignores `mask`. Masked lines still accumulate in `pending`.
- Qualified vector: `q` = `pending & mask`. Selection picks the highest set index of `q` (bit N-1 has top priority).
- FSM has two states, IDLE and PRESENT.
  - IDLE: if `q` ≠ 0, register the selected index into `irq_id`, set `irq_valid` = 1, and go to PRESENT. Otherwise stay in IDLE with `irq_valid` = 0.
  - PRESENT: `irq_id` and `irq_valid` are held stable regardless of changes to `mask`, `pending`, or `irq_in`. Higher-priority arrivals do not preempt the presented index.
  - PRESENT with `irq_ack` = 1: clear `pending[irq_id]`, set `irq_valid` = 0, and go to IDLE.
- `irq_ack` is ignored in IDLE. It has no effect on `pending` there.
- Simultaneous set and clear of the same bit: set wins, so `pending[irq_id]` stays 1 and is re-presented later.
- If the presented line becomes masked while in PRESENT, it is still presented until acked.
- `irq_id` retains its last value while in IDLE. `irq_id` is don't-care when `irq_valid` = 0.
- Reset asserted mid-handshake: all state returns to reset values immediately. Requests captured before reset are lost.

## Timing
- Capture latency: a capture condition at edge k makes `pending` visible after edge k.
- Presentation latency: `irq_valid` rises after edge k+1, so it is seen 2 cycles after the request, provided the FSM is in IDLE and the line is unmasked.
- Ack: `irq_ack` sampled high at edge j drops `irq_valid` and clears the pending bit after edge j.
- The earliest next presentation is after edge j+1. This gives a guaranteed minimum of one cycle with `irq_valid` = 0 between back-to-back presentations.
- Sustained throughput: one acknowledged request per 2 cycles.
- All outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `IRQ_EDGE_EN` defined:
  - Capture condition is `irq_in[i] & ~irq_d[i]`, where `irq_d` is `irq_in` registered each cycle (reset 0).
  - A line held high sets pending once. It must go low and high again to set pending again.
  - A line already high when reset is released is captured as an edge on the first clock edge.
- `IRQ_EDGE_EN` undefined:
  - Capture condition is `irq_in[i]` (level).
  - A line held high re-sets pending every cycle, so an ack on a still-asserted line is overridden (set wins) and the line is re-presented.
  - No history register is instantiated.

## Test plan
- Reset check: assert `rst` mid-PRESENT with `pending` = 8'h81 → `irq_valid` = 0, `pending` = 0, `irq_id` = 0 immediately; with no requests, `irq_valid` stays 0 for ≥10 cycles after release.
- Priority: `mask` = 8'hFF; pulse `irq_in` = 8'h24 for one cycle → `irq_id` = 5, `irq_valid` = 1 two cycles later; ack → `irq_id` = 2 after one idle cycle; ack → `pending` = 0.
- Masking: `mask` = 8'h0F, pulse `irq_in` = 8'h90 → `pending` = 8'h90, `irq_valid` stays 0; set `mask` = 8'hFF → `irq_id` = 7 is presented.
- Hold and no-preempt: line 1 is presented; pulse line 6 while in PRESENT → `irq_id` stays 1 until ack; line 6 is presented after the gap cycle.
- Set-wins: same cycle as ack of `irq_id` = 3, pulse `irq_in[3]` → `pending[3]` stays 1 and line 3 is re-presented.
- Mode: hold `irq_in[0]` high for 6 cycles and ack each presentation → with `IRQ_EDGE_EN`, exactly 1 presentation; without it, presentations repeat until the line drops.
